// File: rtl/gf_pkg.sv
// Shared GF(2^4) definitions: zero symbol, arbiter FSM states and
// exponent<->vector lookup tables for the field generated by x^4+x+1.
package gf_pkg;

  localparam logic [3:0] GF_ZERO = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_HOLD
  } state_t;

  // Index e -> alpha^e as a 4-bit vector; entry 15 is the zero element.
  localparam logic [15:0][3:0] GF_EXP_LUT = '{
    4'h0, 4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5,
    4'hB, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
  };

  // Vector v -> exponent; zero maps to GF_ZERO.
  localparam logic [15:0][3:0] GF_LOG_LUT = '{
    4'hC, 4'hB, 4'hD, 4'h6, 4'h7, 4'h9, 4'hE, 4'h3,
    4'hA, 4'h5, 4'h8, 4'h2, 4'h4, 4'h1, 4'h0, 4'hF
  };

  function automatic logic [3:0] exp2vec(input logic [3:0] e);
    return GF_EXP_LUT[e];
  endfunction

  function automatic logic [3:0] vec2exp(input logic [3:0] v);
    return GF_LOG_LUT[v];
  endfunction

  function automatic logic [3:0] gf_mul_vec(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    s = {1'b0, GF_LOG_LUT[a]} + {1'b0, GF_LOG_LUT[b]};
    if (s >= 5'd15) s = s - 5'd15;
    return GF_EXP_LUT[s[3:0]];
  endfunction

  // b must be non-zero; a zero numerator yields zero.
  function automatic logic [3:0] gf_div_vec(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    if (a == 4'h0) return 4'h0;
    s = {1'b0, GF_LOG_LUT[a]} + 5'd15 - {1'b0, GF_LOG_LUT[b]};
    if (s >= 5'd15) s = s - 5'd15;
    return GF_EXP_LUT[s[3:0]];
  endfunction

endpackage

// File: rtl/Division_IP.sv
// Combinational polynomial long division over GF(2^4), operands and
// quotient in exponent-nibble form (MSB nibble = highest degree).
module Division_IP
  import gf_pkg::*;
#(
  parameter int unsigned IP_WIDTH = 7
) (
  input  logic [4*IP_WIDTH-1:0] i_dividend,
  input  logic [4*IP_WIDTH-1:0] i_divisor,
  output logic [4*IP_WIDTH-1:0] o_quotient
);

  logic [3:0]  w_rem [IP_WIDTH];
  logic [3:0]  w_dvs [IP_WIDTH];
  logic [3:0]  w_q   [IP_WIDTH];
  logic [31:0] w_ds;
  logic [3:0]  w_lead;
  logic        w_dvs_nz;
  logic [3:0]  w_coef;

  always_comb begin
    w_ds     = '0;
    w_lead   = 4'h1;
    w_dvs_nz = 1'b0;
    w_coef   = '0;
    for (int unsigned i = 0; i < IP_WIDTH; i++) begin
      w_rem[i] = exp2vec(i_dividend[4*i +: 4]);
      w_dvs[i] = exp2vec(i_divisor[4*i +: 4]);
      w_q[i]   = 4'h0;
      if (w_dvs[i] != 4'h0) begin
        w_ds     = i;
        w_lead   = w_dvs[i];
        w_dvs_nz = 1'b1;
      end
    end
    // Step k-1 is the current remainder degree; the index matches
    // (t + ds == k-1 + j) keep every array access at a constant index.
    for (int unsigned k = IP_WIDTH; k > 0; k--) begin
      if (w_dvs_nz && k > w_ds) begin
        w_coef = gf_div_vec(w_rem[k-1], w_lead);
        for (int unsigned t = 0; t < IP_WIDTH; t++) begin
          if (t + w_ds + 1 == k) w_q[t] = w_coef;
          for (int unsigned j = 0; j < IP_WIDTH; j++) begin
            if (j <= w_ds && t + w_ds + 1 == k + j)
              w_rem[t] = w_rem[t] ^ gf_mul_vec(w_coef, w_dvs[j]);
          end
        end
      end
    end
    o_quotient = '1;
    for (int unsigned i = 0; i < IP_WIDTH; i++)
      o_quotient[4*i +: 4] = vec2exp(w_q[i]);
  end

endmodule

// File: rtl/gf_div_arbiter.sv
// Round-robin front end sharing one Division_IP between two requesters;
// registers operands, tags the result with its owner and holds it under backpressure.
module gf_div_arbiter
  import gf_pkg::*;
#(
  parameter int unsigned IP_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_0,
  output logic                  in_ready_0,
  input  logic [4*IP_WIDTH-1:0] in_dividend_0,
  input  logic [4*IP_WIDTH-1:0] in_divisor_0,
  input  logic                  in_valid_1,
  output logic                  in_ready_1,
  input  logic [4*IP_WIDTH-1:0] in_dividend_1,
  input  logic [4*IP_WIDTH-1:0] in_divisor_1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*IP_WIDTH-1:0] out_quotient,
  output logic                  out_id,
  output logic                  out_err,
  output logic                  busy
);

  state_t                r_state, w_next;
  logic                  r_rr_last;
  logic [4*IP_WIDTH-1:0] r_dividend, r_divisor;
  logic                  r_id;
  logic                  r_out_valid;
  logic [4*IP_WIDTH-1:0] r_quot;
  logic                  r_out_id;
  logic                  r_err;
  logic                  w_grant_0, w_grant_1;
  logic                  w_dvs_zero;
  logic [4*IP_WIDTH-1:0] w_quot;

  Division_IP #(.IP_WIDTH(IP_WIDTH)) u_div (
    .i_dividend (r_dividend),
    .i_divisor  (r_divisor),
    .o_quotient (w_quot)
  );

  assign w_dvs_zero = (r_divisor == {IP_WIDTH{GF_ZERO}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant_0 || w_grant_1) w_next = ST_CALC;
      ST_CALC: w_next = ST_HOLD;
      ST_HOLD: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // On a conflict the requester that was not served last wins.
  always_comb begin
    w_grant_0  = (r_state == ST_IDLE) && in_valid_0 && (!in_valid_1 || r_rr_last);
    w_grant_1  = (r_state == ST_IDLE) && in_valid_1 && (!in_valid_0 || !r_rr_last);
    in_ready_0 = w_grant_0;
    in_ready_1 = w_grant_1;
    busy       = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last   <= 1'b1;
      r_dividend  <= '1;
      r_divisor   <= '1;
      r_id        <= 1'b0;
      r_out_valid <= 1'b0;
      r_quot      <= '1;
      r_out_id    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_0 || w_grant_1) begin
            r_dividend <= w_grant_1 ? in_dividend_1 : in_dividend_0;
            r_divisor  <= w_grant_1 ? in_divisor_1  : in_divisor_0;
            r_id       <= w_grant_1;
            r_rr_last  <= w_grant_1;
          end
        end
        ST_CALC: begin
          r_quot      <= w_dvs_zero ? '1 : w_quot;
          r_err       <= w_dvs_zero;
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
        end
        ST_HOLD: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_quotient = r_quot;
  assign out_id       = r_out_id;
  assign out_err      = r_err;

endmodule
